// File: rtl/decode_ctrl_if.sv
// Fetch-to-decode bus for decode_ctrl: fetch/hazard inputs, the IF/ID register and stall/flush controls.
// master = pipeline side that drives the fetch and hazard inputs; slave = decode_ctrl.
interface decode_ctrl_if;
  logic [31:0] instr_f;
  logic        valid_f;
  logic [4:0]  rd_e;
  logic        memread_e;
  logic        pcsrc_e;
  logic        dmem_stall;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [1:0]  imm_src_d;
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        stall_m;
  logic        flush_d;
  logic        flush_e;

  modport master (
    output instr_f, valid_f, rd_e, memread_e, pcsrc_e, dmem_stall,
    input  instr_d, valid_d, imm_src_d,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e
  );

  modport slave (
    input  instr_f, valid_f, rd_e, memread_e, pcsrc_e, dmem_stall,
    output instr_d, valid_d, imm_src_d,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e
  );
endinterface

// File: rtl/decode_ctrl.sv
// RV32I decode-stage controller: IF/ID register, ImmSrc decode, load-use/branch/dmem-wait sequencing.
// Optional DECODE_CTRL_PERF_EN adds saturating stall/flush performance counters.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_RUN      | normal flow
// S_LU_STALL | load-use bubble inserted; lu ignored this cycle
// S_MEM_WAIT | frozen on dmem_stall; behaves as RUN on release
module decode_ctrl #(
  parameter logic [31:0] RST_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  decode_ctrl_if.slave bus
`ifdef DECODE_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_stall_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_LU_STALL = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [1:0]  imm_src_d;
  logic [1:0]  imm_src_f;
  logic        lu;
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        stall_m;
  logic        flush_d;
  logic        flush_e;

  always_comb begin
    imm_src_f = IMM_I;
    case (bus.instr_f[6:0])
      7'b0000011: imm_src_f = IMM_I;
      7'b0010011: imm_src_f = IMM_I;
      7'b1100111: imm_src_f = IMM_I;
      7'b0100011: imm_src_f = IMM_S;
      7'b1100011: imm_src_f = IMM_B;
      7'b1101111: imm_src_f = IMM_J;
      default:    imm_src_f = IMM_I;
    endcase
  end

  assign lu = bus.memread_e && (bus.rd_e != 5'd0) && valid_d &&
              ((bus.rd_e == instr_d[19:15]) || (bus.rd_e == instr_d[24:20]));

  // Reset masks every control so a reset during a freeze or bubble is quiet.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    state_nxt = S_RUN;
    if (rst) begin
      state_nxt = S_RUN;
    end else if (bus.dmem_stall) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      stall_m   = 1'b1;
      state_nxt = S_MEM_WAIT;
    end else if (bus.pcsrc_e) begin
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      state_nxt = S_RUN;
    end else if (lu && (state != S_LU_STALL)) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      flush_e   = 1'b1;
      state_nxt = S_LU_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d   <= RST_INSTR;
      valid_d   <= 1'b0;
      imm_src_d <= IMM_I;
    end else if (stall_d) begin
      instr_d   <= instr_d;
      valid_d   <= valid_d;
      imm_src_d <= imm_src_d;
    end else if (flush_d) begin
      instr_d   <= RST_INSTR;
      valid_d   <= 1'b0;
      imm_src_d <= IMM_I;
    end else begin
      instr_d   <= bus.instr_f;
      valid_d   <= bus.valid_f;
      imm_src_d <= imm_src_f;
    end
  end

`ifdef DECODE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall_d && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush_d && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

  assign bus.instr_d   = instr_d;
  assign bus.valid_d   = valid_d;
  assign bus.imm_src_d = imm_src_d;
  assign bus.stall_f   = stall_f;
  assign bus.stall_d   = stall_d;
  assign bus.stall_e   = stall_e;
  assign bus.stall_m   = stall_m;
  assign bus.flush_d   = flush_d;
  assign bus.flush_e   = flush_e;

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: cycle-by-cycle vector table plus hand-written corner sequences.
module tb_decode_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  decode_ctrl_if bus ();

`ifdef DECODE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  decode_ctrl #(.RST_INSTR(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DECODE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] instr_f;
    logic        valid_f;
    logic [4:0]  rd_e;
    logic        memread_e;
    logic        pcsrc_e;
    logic        dmem;
    logic [3:0]  x_stall;   // {f,d,e,m} during the cycle
    logic [1:0]  x_flush;   // {d,e} during the cycle
    logic [31:0] x_instr;   // IF/ID after the edge
    logic        x_valid;
    logic [1:0]  x_imm;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic r, input logic [31:0] i, input logic v,
                              input logic [4:0] rd, input logic mr, input logic pc,
                              input logic dm, input logic [3:0] xs, input logic [1:0] xf,
                              input logic [31:0] xi, input logic xv, input logic [1:0] xm);
    vec_t t;
    t.rst = r; t.instr_f = i; t.valid_f = v; t.rd_e = rd; t.memread_e = mr;
    t.pcsrc_e = pc; t.dmem = dm; t.x_stall = xs; t.x_flush = xf;
    t.x_instr = xi; t.x_valid = xv; t.x_imm = xm;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic [31:0] i, input logic v, input logic [4:0] rd,
                        input logic mr, input logic pc, input logic dm);
    rst           = r;
    bus.instr_f   = i;
    bus.valid_f   = v;
    bus.rd_e      = rd;
    bus.memread_e = mr;
    bus.pcsrc_e   = pc;
    bus.dmem_stall = dm;
  endtask

  task automatic chk_ctl(input string nm, input logic [3:0] xs, input logic [1:0] xf);
    chk({nm, " stall"}, {28'd0, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m}, {28'd0, xs});
    chk({nm, " flush"}, {30'd0, bus.flush_d, bus.flush_e}, {30'd0, xf});
  endtask

  task automatic chk_ifid(input string nm, input logic [31:0] xi, input logic xv, input logic [1:0] xm);
    chk({nm, " instr_d"}, bus.instr_d, xi);
    chk({nm, " valid_d"}, {31'd0, bus.valid_d}, {31'd0, xv});
    chk({nm, " imm_src_d"}, {30'd0, bus.imm_src_d}, {30'd0, xm});
  endtask

  // Inputs are changed 1 time unit after a rising edge; controls sampled just before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    set_in(1'b1, 32'hB6F16175, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

    // reset, decode
    vecs[0]  = mk(1, 32'hB6F16175, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h00000013, 0, 2'b00);
    vecs[1]  = mk(1, 32'hB6F16175, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h00000013, 0, 2'b00);
    vecs[2]  = mk(0, 32'h00500093, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h00500093, 1, 2'b00);
    vecs[3]  = mk(0, 32'h00112023, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h00112023, 1, 2'b01);
    vecs[4]  = mk(0, 32'h00208463, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h00208463, 1, 2'b10);
    vecs[5]  = mk(0, 32'h008000EF, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h008000EF, 1, 2'b11);
    // load-use: one bubble, lu ignored in the bubble cycle
    vecs[6]  = mk(0, 32'h00208133, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h00208133, 1, 2'b00);
    vecs[7]  = mk(0, 32'h00310193, 1, 1, 1, 0, 0, 4'b1100, 2'b01, 32'h00208133, 1, 2'b00);
    vecs[8]  = mk(0, 32'h00310193, 1, 1, 1, 0, 0, 4'b0000, 2'b00, 32'h00310193, 1, 2'b00);
    vecs[9]  = mk(0, 32'h00208133, 1, 0, 1, 0, 0, 4'b0000, 2'b00, 32'h00208133, 1, 2'b00);
    vecs[10] = mk(0, 32'h00000033, 1, 2, 0, 0, 0, 4'b0000, 2'b00, 32'h00000033, 1, 2'b00);
    vecs[11] = mk(0, 32'h00500093, 1, 0, 1, 0, 0, 4'b0000, 2'b00, 32'h00500093, 1, 2'b00);
    // branch flush
    vecs[12] = mk(0, 32'h00112023, 1, 0, 0, 1, 0, 4'b0000, 2'b11, 32'h00000013, 0, 2'b00);
    vecs[13] = mk(0, 32'h008000EF, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h008000EF, 1, 2'b11);
    vecs[14] = mk(0, 32'h00208463, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h00208463, 0, 2'b10);
    vecs[15] = mk(0, 32'h00208133, 1, 1, 1, 0, 0, 4'b0000, 2'b00, 32'h00208133, 1, 2'b00);
    // priority: dmem_stall > pcsrc_e > lu
    vecs[16] = mk(0, 32'h00500093, 1, 1, 1, 1, 1, 4'b1111, 2'b00, 32'h00208133, 1, 2'b00);
    vecs[17] = mk(0, 32'h00500093, 1, 1, 1, 1, 1, 4'b1111, 2'b00, 32'h00208133, 1, 2'b00);
    vecs[18] = mk(0, 32'h00500093, 1, 1, 1, 1, 1, 4'b1111, 2'b00, 32'h00208133, 1, 2'b00);
    vecs[19] = mk(0, 32'h00500093, 1, 1, 1, 1, 0, 4'b0000, 2'b11, 32'h00000013, 0, 2'b00);

    #1;
    for (int i = 0; i < 20; i++) begin
      set_in(vecs[i].rst, vecs[i].instr_f, vecs[i].valid_f, vecs[i].rd_e,
             vecs[i].memread_e, vecs[i].pcsrc_e, vecs[i].dmem);
      #3;
      chk_ctl($sformatf("v%0d", i), vecs[i].x_stall, vecs[i].x_flush);
      tick();
      chk_ifid($sformatf("v%0d", i), vecs[i].x_instr, vecs[i].x_valid, vecs[i].x_imm);
    end

    // freeze of 2 cycles keeps a pending load-use; it fires on release, then one bubble
    set_in(0, 32'h00208133, 1, 0, 0, 0, 0);
    tick();
    set_in(0, 32'h00500093, 1, 1, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      #3;
      chk_ctl($sformatf("frz%0d", k), 4'b1111, 2'b00);
      tick();
      chk_ifid($sformatf("frz%0d", k), 32'h00208133, 1'b1, 2'b00);
    end
    set_in(0, 32'h00500093, 1, 1, 1, 0, 0);
    #3;
    chk_ctl("frz_rel", 4'b1100, 2'b01);
    tick();
    chk_ifid("frz_rel", 32'h00208133, 1'b1, 2'b00);
    #3;
    chk_ctl("frz_bub", 4'b0000, 2'b00);
    tick();
    chk_ifid("frz_bub", 32'h00500093, 1'b1, 2'b00);

    // reset during a memory wait aborts at once
    set_in(0, 32'h00208133, 1, 0, 0, 0, 0);
    tick();
    set_in(0, 32'h00500093, 1, 1, 1, 0, 1);
    tick();
    set_in(1, 32'h00500093, 1, 1, 1, 0, 1);
    #3;
    chk_ctl("rst_wait", 4'b0000, 2'b00);
    tick();
    chk_ifid("rst_wait", 32'h00000013, 1'b0, 2'b00);
    set_in(0, 32'h00208133, 1, 1, 1, 0, 0);
    #3;
    chk_ctl("rst_wait_run", 4'b0000, 2'b00);
    tick();

    // reset during the load-use bubble; a later hazard stalls normally
    set_in(0, 32'h00500093, 1, 1, 1, 0, 0);
    #3;
    chk_ctl("lu_pre", 4'b1100, 2'b01);
    tick();
    set_in(1, 32'h00208133, 1, 0, 0, 0, 0);
    tick();
    chk_ifid("rst_lu", 32'h00000013, 1'b0, 2'b00);
    set_in(0, 32'h00208133, 1, 0, 0, 0, 0);
    tick();
    set_in(0, 32'h00500093, 1, 2, 1, 0, 0);
    #3;
    chk_ctl("lu_post", 4'b1100, 2'b01);
    tick();

`ifdef DECODE_CTRL_PERF_EN
    set_in(1, 32'h00000013, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 32'h00208133, 1, 0, 0, 0, 0);
    tick();
    set_in(0, 32'h00500093, 1, 1, 1, 0, 0);
    tick();
    set_in(0, 32'h00500093, 1, 0, 0, 1, 0);
    tick();
    tick();
    set_in(0, 32'h00500093, 1, 0, 0, 0, 0);
    tick();
    chk("perf_stall_cnt", perf_stall_cnt, 32'd1);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
